// File: rtl/run_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : run_tx_if
//  Description : Request/response bundle for the run_tx run-length serialiser.
//                The master offers runs and observes the serial stream, the
//                detector prediction and the status pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
interface run_tx_if;
    logic       in_valid;
    logic       in_bit;
    logic [3:0] in_len;
    logic       in_ready;
    logic       w;
    logic       z_exp;
    logic       done;
    logic       err;

    modport master (
        output in_valid,
        output in_bit,
        output in_len,
        input  in_ready,
        input  w,
        input  z_exp,
        input  done,
        input  err
    );

    modport slave (
        input  in_valid,
        input  in_bit,
        input  in_len,
        output in_ready,
        output w,
        output z_exp,
        output done,
        output err
    );
endinterface
`default_nettype wire

// File: rtl/run_tx.sv
`default_nettype none
// ============================================================================
//  Module      : run_tx
//  Description : Drives a registered serial stream w as a sequence of
//                constant-level runs (level, length 1..15) requested over a
//                valid/ready handshake, and predicts the output z of a
//                two-in-a-row detector watching w.
//  Revision    : 1.0 - initial release
// ============================================================================
module run_tx (
    input  wire       clk,
    input  wire       reset,
    run_tx_if.slave   bus
);

    // One-hot controller encoding: bit 0 = IDLE, bit 1 = SEND.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b01,
        ST_SEND = 2'b10
    } state_t;

    localparam logic [1:0] c_V_SAT = 2'd2;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic       r_w;
    logic       w_w_nxt;
    logic       r_done;
    logic       w_done_nxt;
    logic       r_err;
    logic       w_err_nxt;
    logic       w_ready;
    logic       w_accept;
    logic       w_load;

    // Detector model state.
    logic       r_s1;
    logic       r_s2;
    logic [1:0] r_v;
    logic       r_z;

    // Ready in IDLE, and on the last cycle of a run so runs can chain with no gap.
    assign w_ready  = (r_state == ST_IDLE) || ((r_state == ST_SEND) && (r_cnt == 4'd0));
    assign w_accept = bus.in_valid && w_ready;

    // Next-state and next-output decode; a zero-length request is dropped with err.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_w_nxt     = r_w;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_load = w_accept;
            end
            ST_SEND: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                    w_load      = w_accept;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (w_load) begin
            if (bus.in_len != 4'd0) begin
                w_w_nxt     = bus.in_bit;
                w_cnt_nxt   = bus.in_len - 4'd1;
                w_state_nxt = ST_SEND;
            end else begin
                w_err_nxt   = 1'b1;
                w_state_nxt = ST_IDLE;
            end
        end
    end

    // Controller and stream registers; reset aborts any run without a done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_w     <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_w     <= w_w_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Detector shadow: z_exp is computed from the next s1/s2/v values so the
    // flop output equals (v==2)&&(s1==s2) in the same cycle the detector shows z.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_v  <= 2'd0;
            r_z  <= 1'b0;
        end else begin
            r_s1 <= r_w;
            r_s2 <= r_s1;
            r_v  <= (r_v == c_V_SAT) ? c_V_SAT : r_v + 2'd1;
            r_z  <= (r_v != 2'd0) && (r_w == r_s1);
        end
    end

    assign bus.in_ready = w_ready;
    assign bus.w        = r_w;
    assign bus.z_exp    = r_z;
    assign bus.done     = r_done;
    assign bus.err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_run_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_run_tx
//  Description : Directed checks of run_tx (single runs, back-to-back runs,
//                zero-length requests, ignored requests, mid-run reset) and a
//                randomised phase against a small run model, with a
//                two-in-a-row detector running alongside for z.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_run_tx;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    run_tx_if bus ();

    run_tx u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Two-in-a-row detector sampling w on the shared clock/reset.
    logic       d_s1;
    logic       d_s2;
    logic [1:0] d_v;
    logic       d_z;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_s1 <= 1'b0;
            d_s2 <= 1'b0;
            d_v  <= 2'd0;
        end else begin
            d_s1 <= bus.w;
            d_s2 <= d_s1;
            d_v  <= (d_v == 2'd2) ? 2'd2 : d_v + 2'd1;
        end
    end
    assign d_z = (d_v == 2'd2) && (d_s1 == d_s2);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and sample just after the edge; z is checked every cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        chk("z_vs_detector", {3'b0, bus.z_exp}, {3'b0, d_z});
    endtask

    task automatic offer(input logic v, input logic b, input logic [3:0] l);
        bus.in_valid = v;
        bus.in_bit   = b;
        bus.in_len   = l;
    endtask

    // Random-phase model: m_rem = w cycles still to go including the current one.
    int   m_rem;
    int   n_rem;
    logic m_w, m_done, m_err;
    logic n_w, n_done, n_err;
    logic m_ready, acc;

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        offer(1'b0, 1'b0, 4'd0);

        // ---------------- reset state ----------------
        tick();
        tick();
        chk("rst_ready", {3'b0, bus.in_ready}, 4'd1);
        chk("rst_w",     {3'b0, bus.w},        4'd0);
        chk("rst_z",     {3'b0, bus.z_exp},    4'd0);
        chk("rst_done",  {3'b0, bus.done},     4'd0);
        chk("rst_err",   {3'b0, bus.err},      4'd0);
        reset = 1'b0;

        // ---------------- run (1, len 3), accepted on first edge ----------------
        offer(1'b1, 1'b1, 4'd3);
        tick();
        offer(1'b0, 1'b0, 4'd0);
        chk("r3_c1_w",     {3'b0, bus.w},        4'd1);
        chk("r3_c1_ready", {3'b0, bus.in_ready}, 4'd0);
        chk("r3_c1_z",     {3'b0, bus.z_exp},    4'd0);
        tick();
        chk("r3_c2_w",     {3'b0, bus.w},        4'd1);
        chk("r3_c2_ready", {3'b0, bus.in_ready}, 4'd0);
        chk("r3_c2_z",     {3'b0, bus.z_exp},    4'd0);
        chk("r3_c2_done",  {3'b0, bus.done},     4'd0);
        tick();
        chk("r3_c3_w",     {3'b0, bus.w},        4'd1);
        chk("r3_c3_ready", {3'b0, bus.in_ready}, 4'd1);
        chk("r3_c3_z",     {3'b0, bus.z_exp},    4'd1);
        chk("r3_c3_done",  {3'b0, bus.done},     4'd0);
        tick();
        chk("r3_done",     {3'b0, bus.done},     4'd1);
        chk("r3_idle_w",   {3'b0, bus.w},        4'd1);
        tick();
        chk("r3_done_off", {3'b0, bus.done},     4'd0);

        // ---------------- back-to-back (0,len 2) then (1,len 1) ----------------
        offer(1'b1, 1'b0, 4'd2);
        tick();
        chk("b2b_c1_w",     {3'b0, bus.w},        4'd0);
        chk("b2b_c1_ready", {3'b0, bus.in_ready}, 4'd0);
        tick();
        chk("b2b_c2_w",     {3'b0, bus.w},        4'd0);
        chk("b2b_c2_ready", {3'b0, bus.in_ready}, 4'd1);
        chk("b2b_c2_done",  {3'b0, bus.done},     4'd0);
        offer(1'b1, 1'b1, 4'd1);
        tick();
        offer(1'b0, 1'b0, 4'd0);
        chk("b2b_c3_w",     {3'b0, bus.w},        4'd1);
        chk("b2b_c3_done",  {3'b0, bus.done},     4'd1);
        chk("b2b_c3_ready", {3'b0, bus.in_ready}, 4'd1);
        tick();
        chk("b2b_c4_done",  {3'b0, bus.done},     4'd1);
        chk("b2b_c4_w",     {3'b0, bus.w},        4'd1);
        tick();
        chk("b2b_c5_done",  {3'b0, bus.done},     4'd0);

        // ---------------- zero-length request ----------------
        offer(1'b1, 1'b0, 4'd0);
        tick();
        offer(1'b0, 1'b0, 4'd0);
        chk("len0_err",    {3'b0, bus.err},      4'd1);
        chk("len0_w",      {3'b0, bus.w},        4'd1);
        chk("len0_ready",  {3'b0, bus.in_ready}, 4'd1);
        chk("len0_done",   {3'b0, bus.done},     4'd0);
        tick();
        chk("len0_err_off",{3'b0, bus.err},      4'd0);
        chk("len0_done2",  {3'b0, bus.done},     4'd0);

        // ---------------- request offered while busy is ignored ----------------
        offer(1'b1, 1'b1, 4'd2);
        tick();
        offer(1'b1, 1'b0, 4'd5);
        chk("ign_c1_ready", {3'b0, bus.in_ready}, 4'd0);
        tick();
        offer(1'b0, 1'b0, 4'd0);
        chk("ign_c2_w",     {3'b0, bus.w},        4'd1);
        chk("ign_c2_ready", {3'b0, bus.in_ready}, 4'd1);
        tick();
        chk("ign_done",     {3'b0, bus.done},     4'd1);
        chk("ign_w_held",   {3'b0, bus.w},        4'd1);
        chk("ign_ready",    {3'b0, bus.in_ready}, 4'd1);

        // ---------------- reset during cycle 2 of a len-8 run ----------------
        offer(1'b1, 1'b1, 4'd8);
        tick();
        offer(1'b0, 1'b0, 4'd0);
        tick();
        chk("abort_pre_w",  {3'b0, bus.w},        4'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_w",      {3'b0, bus.w},        4'd0);
        chk("abort_z",      {3'b0, bus.z_exp},    4'd0);
        chk("abort_ready",  {3'b0, bus.in_ready}, 4'd1);
        chk("abort_done",   {3'b0, bus.done},     4'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("abort_done2",  {3'b0, bus.done},     4'd0);
        chk("abort_w2",     {3'b0, bus.w},        4'd0);

        // ---------------- randomised runs against the model ----------------
        m_rem  = 0;
        m_w    = 1'b0;
        m_done = 1'b0;
        m_err  = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            offer(($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            m_ready = (m_rem <= 1);
            chk("rnd_ready", {3'b0, bus.in_ready}, {3'b0, m_ready});
            acc    = bus.in_valid && m_ready;
            n_done = (m_rem == 1);
            n_err  = 1'b0;
            n_w    = m_w;
            n_rem  = (m_rem > 0) ? m_rem - 1 : 0;
            if (acc) begin
                if (bus.in_len != 4'd0) begin
                    n_w   = bus.in_bit;
                    n_rem = int'(bus.in_len);
                end else begin
                    n_err = 1'b1;
                end
            end
            tick();
            m_rem  = n_rem;
            m_w    = n_w;
            m_done = n_done;
            m_err  = n_err;
            chk("rnd_w",    {3'b0, bus.w},    {3'b0, m_w});
            chk("rnd_done", {3'b0, bus.done}, {3'b0, m_done});
            chk("rnd_err",  {3'b0, bus.err},  {3'b0, m_err});
        end
        offer(1'b0, 1'b0, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
